tag_write_scheduler: RTL and testbench
======================================

# tag_write_scheduler

Sequencer and arbiter for the single write port of the per-core MOESI tag array. It accepts tag/state/LRU update requests from the core-side controller and the snoop controller, buffers each in a 2-entry FIFO, and arbitrates them onto the array write port. Snoop updates have priority, with a starvation bound for the core. On command it also runs a full-cache invalidate sweep over every set and way. It sits between the two cache controllers and the tag array write interface.

## Interface
- SETS, 128, number of sets; power of 2, at least 2
- WAYS, 4, ways per set; power of 2, at least 2
- TAG_WIDTH, 19, tag bits
- LRU_BITS, 2, LRU bits per way
- STARVE_LIMIT, 4, consecutive cycles a pending core request may lose before it is forced through; at least 1
- SW = $clog2(SETS); WW = $clog2(WAYS)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- core_req_valid / core_req_ready  in / out  1 each  core request handshake
- core_req_set, core_req_way, core_req_tag  in  SW / WW / TAG_WIDTH  core target and tag
- core_req_line_valid, core_req_state, core_req_lru  in  1 / 3 / LRU_BITS  core payload
- snoop_req_valid / snoop_req_ready, plus snoop_req_set, _way, _tag, _line_valid, _state, _lru  same widths as core  snoop request
- flush_start  in  1  request a full invalidate sweep
- flush_busy  out  1  high from flush acceptance until the sweep completes
- flush_done  out  1  one-cycle pulse after the last sweep write
- write_en  out  1  tag array write strobe
- write_set, write_way, write_tag, write_valid, write_state, write_lru  out  SW / WW / TAG_WIDTH / 1 / 3 / LRU_BITS  tag array write fields

## Operation
- FSM states: IDLE, DRAIN, FLUSH, DONE.
- IDLE:
  - Each request FIFO accepts on valid&&ready.
  - ready = (FIFO not full) && state==IDLE. No bypass: a push into a full FIFO is never attempted.
  - flush_start moves to DRAIN. flush_start is ignored in every other state.
- DRAIN:
  - Both ready outputs are low.
  - FIFOs continue to issue writes.
  - Move to FLUSH in the cycle both FIFOs are empty and no write is being issued.
- FLUSH:
  - One write per cycle. A counter {set, way} starts at 0,0. Way increments first; on way wrap, set increments.
  - Each sweep write drives tag=0, valid=0, state=3'b000 (I), lru=0.
  - After writing (SETS-1, WAYS-1), go to DONE.
- DONE: flush_done=1 for one cycle, then return to IDLE.
- flush_busy=1 in DRAIN, FLUSH and DONE.
- Arbitration, evaluated each cycle in IDLE/DRAIN over the FIFO heads:
  - Only snoop non-empty: grant snoop.
  - Only core non-empty: grant core.
  - Both non-empty: grant snoop, unless starve_cnt == STARVE_LIMIT, in which case grant core.
- starve_cnt behaviour:
  - Increments (saturating at STARVE_LIMIT) on each cycle the core head is pending but not granted.
  - Clears on a core grant, or when the core FIFO is empty.
- A grant pops the chosen FIFO head and registers its fields onto write_* with write_en=1. At most one write per cycle.
- Same set/way conflicts are not merged. Writes land in grant order, so the later grant overwrites the earlier one.
- FIFOs preserve per-source order. There is no ordering between sources beyond arbitration.
- state codes are passed through unchanged. Values are not validated.

## Timing
- Reset, asynchronous, sets:
  - FSM to IDLE, FIFOs empty, starve_cnt=0, sweep counter=0.
  - write_en=0 and all write_* fields 0.
  - flush_busy=0, flush_done=0.
  - core_req_ready=0 and snoop_req_ready=0 while rst_n is low. Both go to 1 in the first cycle after deassertion.
- Reset mid-flush: sweep aborts, no flush_done, IDLE after release.
- Latency: a request accepted at edge N with an empty FIFO and no competition gives write_en=1 in the cycle after edge N+1, one cycle in the FIFO.
- Sustained throughput is 1 write per cycle. The ready of a full FIFO rises in the cycle after a pop.
- Simultaneous push and pop on a non-full FIFO is allowed. Occupancy is unchanged.
- Sweep duration:
  - FLUSH lasts exactly SETS*WAYS cycles, with write_en=1 on every one.
  - flush_done is asserted in the cycle after the last sweep write. write_en=0 in that cycle.
- flush_start asserted together with a request handshake in IDLE: the request is accepted and is written during DRAIN, before the sweep.

## Test plan
- Single core request (set 5, way 2, tag 0x1234, state 3'b100, valid 1, lru 1): the registered write_* fields match these values, with write_en high for exactly one cycle, two cycles after acceptance.
- Continuous snoop and core traffic with STARVE_LIMIT=4: the core is granted on at most every 5th write, and no core request waits more than 5 cycles at the FIFO head.
- Core request holds valid while its FIFO is full: ready stays 0, and no data is lost or duplicated across 6 back-to-back requests.
- flush_start with 2 queued requests: those 2 writes issue first, then 512 sweep writes (SETS=128, WAYS=4) with valid=0 and state=0. flush_done pulses once, and ready stays 0 until IDLE.
- rst_n asserted at sweep write 100: write_en drops immediately, no flush_done is seen, and a new request after release is written normally.
- Snoop and core both target set 3, way 1 in the same cycle: the snoop write issues first, then the core write in the next cycle.

Source files
------------

// File: rtl/tag_write_scheduler.sv
// tag_write_scheduler
//   Sequences tag/state/LRU updates from the core-side and snoop controllers
//   onto the single write port of the MOESI tag array, and runs a
//   full-cache invalidate sweep on command.
//
//   Each source is buffered in a 2-entry FIFO. Snoop heads win arbitration
//   unless the core head has lost STARVE_LIMIT consecutive cycles, in which
//   case the core is forced through. A flush first drains both FIFOs
//   (DRAIN), then writes every {set, way} with an invalid line (FLUSH), then
//   pulses flush_done (DONE).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   core_req_*                 core-side update request (valid/ready handshake)
//   snoop_req_*                snoop update request (valid/ready handshake)
//   flush_start                request an invalidate sweep (honoured in IDLE only)
//   flush_busy                 high from flush acceptance until sweep completes
//   flush_done                 one-cycle pulse after the last sweep write
//   write_en, write_*          registered tag array write strobe and fields

module tag_write_scheduler_fifo #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [PW-1:0] push_data,
    input  logic          pop,
    output logic [PW-1:0] head,
    output logic          empty,
    output logic          full
);

    logic [PW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

endmodule

module tag_write_scheduler #(
    parameter  int SETS         = 128,
    parameter  int WAYS         = 4,
    parameter  int TAG_WIDTH    = 19,
    parameter  int LRU_BITS     = 2,
    parameter  int STARVE_LIMIT = 4,
    localparam int SW           = $clog2(SETS),
    localparam int WW           = $clog2(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 core_req_valid,
    output logic                 core_req_ready,
    input  logic [SW-1:0]        core_req_set,
    input  logic [WW-1:0]        core_req_way,
    input  logic [TAG_WIDTH-1:0] core_req_tag,
    input  logic                 core_req_line_valid,
    input  logic [2:0]           core_req_state,
    input  logic [LRU_BITS-1:0]  core_req_lru,

    input  logic                 snoop_req_valid,
    output logic                 snoop_req_ready,
    input  logic [SW-1:0]        snoop_req_set,
    input  logic [WW-1:0]        snoop_req_way,
    input  logic [TAG_WIDTH-1:0] snoop_req_tag,
    input  logic                 snoop_req_line_valid,
    input  logic [2:0]           snoop_req_state,
    input  logic [LRU_BITS-1:0]  snoop_req_lru,

    input  logic                 flush_start,
    output logic                 flush_busy,
    output logic                 flush_done,

    output logic                 write_en,
    output logic [SW-1:0]        write_set,
    output logic [WW-1:0]        write_way,
    output logic [TAG_WIDTH-1:0] write_tag,
    output logic                 write_valid,
    output logic [2:0]           write_state,
    output logic [LRU_BITS-1:0]  write_lru
);

    typedef struct packed {
        logic [SW-1:0]        set;
        logic [WW-1:0]        way;
        logic [TAG_WIDTH-1:0] tag;
        logic                 line_valid;
        logic [2:0]           state;
        logic [LRU_BITS-1:0]  lru;
    } req_t;

    localparam int PW = $bits(req_t);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int AW = SW + WW;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    state_t          state;
    state_t          state_nxt;

    req_t            core_in, snoop_in;
    req_t            core_head, snoop_head;
    req_t            grant_data;
    logic            core_empty, core_full;
    logic            snoop_empty, snoop_full;
    logic            core_push, snoop_push;
    logic            grant_core, grant_snoop;
    logic            arb_active;
    logic            start_sweep;
    logic            starve_hit;
    logic [CW-1:0]   starve_cnt;
    logic [AW-1:0]   sweep_cnt;
    logic [AW-1:0]   sweep_nxt;
    logic            sweep_last;

    assign core_in  = '{set: core_req_set, way: core_req_way, tag: core_req_tag,
                        line_valid: core_req_line_valid, state: core_req_state,
                        lru: core_req_lru};
    assign snoop_in = '{set: snoop_req_set, way: snoop_req_way, tag: snoop_req_tag,
                        line_valid: snoop_req_line_valid, state: snoop_req_state,
                        lru: snoop_req_lru};

    // Gating with rst_n keeps both readies low for the whole reset assertion,
    // even though the state register already reads IDLE.
    assign core_req_ready  = rst_n && (state == IDLE) && !core_full;
    assign snoop_req_ready = rst_n && (state == IDLE) && !snoop_full;
    assign core_push       = core_req_valid && core_req_ready;
    assign snoop_push      = snoop_req_valid && snoop_req_ready;

    tag_write_scheduler_fifo #(.PW(PW)) u_core_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (core_push),
        .push_data (core_in),
        .pop       (grant_core),
        .head      (core_head),
        .empty     (core_empty),
        .full      (core_full)
    );

    tag_write_scheduler_fifo #(.PW(PW)) u_snoop_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (snoop_push),
        .push_data (snoop_in),
        .pop       (grant_snoop),
        .head      (snoop_head),
        .empty     (snoop_empty),
        .full      (snoop_full)
    );

    // ---- arbitration over FIFO heads ----
    assign arb_active  = (state == IDLE) || (state == DRAIN);
    assign starve_hit  = (starve_cnt == CW'(STARVE_LIMIT));
    assign grant_snoop = arb_active && !snoop_empty && (core_empty || !starve_hit);
    assign grant_core  = arb_active && !core_empty && (snoop_empty || starve_hit);
    assign grant_data  = grant_snoop ? snoop_head : core_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!core_empty && !grant_core && arb_active) begin
            if (!starve_hit) starve_cnt <= starve_cnt + CW'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Sweep address: way in the low bits so it advances first. The counter
    // wraps back to zero on the last write, ready for the next flush.
    assign sweep_nxt   = sweep_cnt + AW'(1);
    assign sweep_last  = (sweep_cnt == {AW{1'b1}});
    assign start_sweep = (state == DRAIN) && core_empty && snoop_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt <= '0;
        end else if (state == FLUSH) begin
            sweep_cnt <= sweep_nxt;
        end
    end

    // ---- FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flush_start) state_nxt = DRAIN;
            DRAIN:   if (start_sweep) state_nxt = FLUSH;
            FLUSH:   if (sweep_last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign flush_busy = (state != IDLE);
    assign flush_done = (state == DONE);

    // ---- registered array write port ----
    // The sweep write for an address is registered one edge ahead, so the
    // FLUSH state spans exactly SETS*WAYS cycles with write_en high throughout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en    <= 1'b0;
            write_set   <= '0;
            write_way   <= '0;
            write_tag   <= '0;
            write_valid <= 1'b0;
            write_state <= 3'b000;
            write_lru   <= '0;
        end else begin
            write_en <= 1'b0;
            if (grant_snoop || grant_core) begin
                write_en    <= 1'b1;
                write_set   <= grant_data.set;
                write_way   <= grant_data.way;
                write_tag   <= grant_data.tag;
                write_valid <= grant_data.line_valid;
                write_state <= grant_data.state;
                write_lru   <= grant_data.lru;
            end else if (start_sweep || (state == FLUSH && !sweep_last)) begin
                write_en    <= 1'b1;
                write_set   <= start_sweep ? '0 : sweep_nxt[AW-1:WW];
                write_way   <= start_sweep ? '0 : sweep_nxt[WW-1:0];
                write_tag   <= '0;
                write_valid <= 1'b0;
                write_state <= 3'b000;
                write_lru   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tag_write_scheduler.sv
// Self-checking bench for tag_write_scheduler: directed steps with a
// per-source scoreboard and an invalidate-sweep reference sequence.
module tb_tag_write_scheduler;

    localparam int SETS = 128, WAYS = 4, TAG_WIDTH = 19, LRU_BITS = 2;
    localparam int STARVE_LIMIT = 4, SW = 7, WW = 2, NSWEEP = SETS * WAYS;

    typedef struct packed {
        logic [SW-1:0]        set;
        logic [WW-1:0]        way;
        logic [TAG_WIDTH-1:0] tag;
        logic                 v;
        logic [2:0]           st;
        logic [LRU_BITS-1:0]  lru;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 core_req_valid, core_req_ready;
    logic [SW-1:0]        core_req_set;
    logic [WW-1:0]        core_req_way;
    logic [TAG_WIDTH-1:0] core_req_tag;
    logic                 core_req_line_valid;
    logic [2:0]           core_req_state;
    logic [LRU_BITS-1:0]  core_req_lru;
    logic                 snoop_req_valid, snoop_req_ready;
    logic [SW-1:0]        snoop_req_set;
    logic [WW-1:0]        snoop_req_way;
    logic [TAG_WIDTH-1:0] snoop_req_tag;
    logic                 snoop_req_line_valid;
    logic [2:0]           snoop_req_state;
    logic [LRU_BITS-1:0]  snoop_req_lru;
    logic                 flush_start, flush_busy, flush_done;
    logic                 write_en;
    logic [SW-1:0]        write_set;
    logic [WW-1:0]        write_way;
    logic [TAG_WIDTH-1:0] write_tag;
    logic                 write_valid;
    logic [2:0]           write_state;
    logic [LRU_BITS-1:0]  write_lru;

    tag_write_scheduler #(
        .SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TAG_WIDTH),
        .LRU_BITS(LRU_BITS), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_set(core_req_set), .core_req_way(core_req_way),
        .core_req_tag(core_req_tag), .core_req_line_valid(core_req_line_valid),
        .core_req_state(core_req_state), .core_req_lru(core_req_lru),
        .snoop_req_valid(snoop_req_valid), .snoop_req_ready(snoop_req_ready),
        .snoop_req_set(snoop_req_set), .snoop_req_way(snoop_req_way),
        .snoop_req_tag(snoop_req_tag), .snoop_req_line_valid(snoop_req_line_valid),
        .snoop_req_state(snoop_req_state), .snoop_req_lru(snoop_req_lru),
        .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done),
        .write_en(write_en), .write_set(write_set), .write_way(write_way),
        .write_tag(write_tag), .write_valid(write_valid),
        .write_state(write_state), .write_lru(write_lru)
    );

    int   checks = 0;
    int   errors = 0;
    rec_t core_stim[$], snoop_stim[$];
    rec_t core_exp[$], snoop_exp[$];
    bit   sweep_armed = 1'b0;
    int   sweep_idx = 0;
    bit   done_due = 1'b0;
    int   done_count = 0;
    int   snoop_run = 0;
    bit   saw_core_stall = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t out_rec();
        return rec_t'({write_set, write_way, write_tag, write_valid, write_state, write_lru});
    endfunction

    function automatic int pending();
        return core_stim.size() + snoop_stim.size() + core_exp.size() + snoop_exp.size();
    endfunction

    function automatic rec_t mk(input int s, input int w, input int t,
                                input bit v, input int st, input int l);
        rec_t r;
        r.set = SW'(s); r.way = WW'(w); r.tag = TAG_WIDTH'(t);
        r.v = v; r.st = 3'(st); r.lru = LRU_BITS'(l);
        return r;
    endfunction

    task automatic drive();
        rec_t c, s;
        c = (core_stim.size() > 0) ? core_stim[0] : '0;
        s = (snoop_stim.size() > 0) ? snoop_stim[0] : '0;
        core_req_valid = (core_stim.size() > 0);
        {core_req_set, core_req_way, core_req_tag, core_req_line_valid,
         core_req_state, core_req_lru} = c;
        snoop_req_valid = (snoop_stim.size() > 0);
        {snoop_req_set, snoop_req_way, snoop_req_tag, snoop_req_line_valid,
         snoop_req_state, snoop_req_lru} = s;
    endtask

    // One clock: drive, note handshakes, then check the write just registered.
    // Snoop tags carry bit 18 set, core tags clear, so each write names its source.
    task automatic step();
        bit   acc_c, acc_s;
        logic exp_done;
        rec_t r, e;
        drive();
        if (flush_busy) chk("ready_low_while_busy", {core_req_ready, snoop_req_ready}, 2'b00);
        acc_c = core_req_valid && core_req_ready;
        acc_s = snoop_req_valid && snoop_req_ready;
        if (rst_n && core_req_valid && !core_req_ready && !flush_busy) saw_core_stall = 1'b1;
        @(posedge clk);
        #1;
        exp_done = done_due;
        done_due = 1'b0;
        r = out_rec();
        if (write_en === 1'b1) begin
            if (r.tag[18] && snoop_exp.size() > 0) begin
                e = snoop_exp.pop_front();
                chk("snoop_write", r, e);
                if (core_exp.size() > 0) begin
                    snoop_run++;
                    chk("core_wait_within_limit", snoop_run <= STARVE_LIMIT, 1);
                end else begin
                    snoop_run = 0;
                end
            end else if (!r.tag[18] && core_exp.size() > 0) begin
                e = core_exp.pop_front();
                chk("core_write", r, e);
                if (snoop_exp.size() > 0) chk("core_wins_only_at_limit", snoop_run, STARVE_LIMIT);
                snoop_run = 0;
            end else if (sweep_armed && sweep_idx < NSWEEP) begin
                e = mk(sweep_idx / WAYS, sweep_idx % WAYS, 0, 1'b0, 0, 0);
                chk("sweep_write", r, e);
                sweep_idx++;
                if (sweep_idx == NSWEEP) done_due = 1'b1;
            end else begin
                chk("unexpected_write", write_en, 1'b0);
            end
        end else begin
            snoop_run = 0;
            if (core_exp.size() + snoop_exp.size() > 0)
                chk("idle_with_pending_request", write_en, 1'b1);
        end
        chk("flush_done", flush_done, exp_done);
        if (flush_done === 1'b1) done_count++;
        if (acc_c) core_exp.push_back(core_stim.pop_front());
        if (acc_s) snoop_exp.push_back(snoop_stim.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rec_t r1, rc, rs;
        rst_n = 1'b0;
        flush_start = 1'b0;
        drive();
        #3;
        chk("reset_write_en", write_en, 1'b0);
        chk("reset_write_fields", out_rec(), '0);
        chk("reset_ready", {core_req_ready, snoop_req_ready}, 2'b00);
        chk("reset_flush_flags", {flush_busy, flush_done}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", {core_req_ready, snoop_req_ready}, 2'b11);

        // Single core request: latency and exact write fields.
        r1 = mk(5, 2, 'h1234, 1'b1, 3'b100, 1);
        core_stim.push_back(r1);
        step();
        chk("lat_not_yet", write_en, 1'b0);
        step();
        chk("lat_write_en", write_en, 1'b1);
        chk("lat_fields", out_rec(), r1);
        step();
        chk("lat_one_cycle", write_en, 1'b0);

        // Continuous two-source traffic: starvation bound and 1 write/cycle.
        for (int i = 0; i < 20; i++)
            core_stim.push_back(mk(i, i % 4, 'h100 + i, 1'b1, i % 8, i % 4));
        for (int i = 0; i < 60; i++)
            snoop_stim.push_back(mk(127 - i, (i + 1) % 4, 'h40000 | i, i % 2, (i + 3) % 8, 3 - i % 4));
        for (int k = 0; k < 400 && pending() > 0; k++) step();
        chk("cont_drained", pending(), 0);

        // Core held valid into a full FIFO: stalls, no loss or duplication.
        saw_core_stall = 1'b0;
        for (int i = 0; i < 6; i++)
            core_stim.push_back(mk(10 + i, i % 4, 'h2000 + i, 1'b1, 3'b011, 2));
        for (int i = 0; i < 12; i++)
            snoop_stim.push_back(mk(40 + i, 3, 'h41000 + i, 1'b0, 3'b001, 0));
        for (int k = 0; k < 200 && pending() > 0; k++) step();
        chk("full_drained", pending(), 0);
        chk("core_stall_seen", saw_core_stall, 1'b1);

        // Flush with two requests accepted alongside flush_start.
        core_stim.push_back(mk(7, 1, 'h0abc, 1'b1, 3'b010, 3));
        snoop_stim.push_back(mk(9, 0, 'h40def, 1'b1, 3'b110, 1));
        sweep_armed = 1'b1;
        sweep_idx = 0;
        done_count = 0;
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        chk("busy_after_start", flush_busy, 1'b1);
        chk("requests_accepted", core_exp.size() + snoop_exp.size(), 2);
        for (int k = 0; k < 700 && done_count == 0; k++) step();
        chk("sweep_write_count", sweep_idx, NSWEEP);
        chk("done_pulse_count", done_count, 1);
        step();
        chk("idle_after_done", {flush_busy, core_req_ready, snoop_req_ready}, 3'b011);
        repeat (3) step();
        chk("done_single_pulse", done_count, 1);
        sweep_armed = 1'b0;

        // Reset in the middle of a sweep.
        sweep_armed = 1'b1;
        sweep_idx = 0;
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        for (int k = 0; k < 300 && sweep_idx < 100; k++) step();
        chk("sweep_reached_100", sweep_idx, 100);
        rst_n = 1'b0;
        #1;
        chk("abort_write_en", write_en, 1'b0);
        chk("abort_fields", out_rec(), '0);
        chk("abort_flags", {flush_busy, flush_done, core_req_ready, snoop_req_ready}, 4'b0000);
        sweep_armed = 1'b0;
        done_due = 1'b0;
        snoop_run = 0;
        core_exp.delete();
        snoop_exp.delete();
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        chk("abort_ready_release", {core_req_ready, snoop_req_ready, flush_busy}, 3'b110);
        repeat (6) step();
        chk("no_done_after_abort", done_count, 1);
        r1 = mk(33, 3, 'h0777, 1'b1, 3'b101, 2);
        core_stim.push_back(r1);
        step();
        step();
        chk("post_abort_write", {write_en, out_rec()}, {1'b1, r1});
        step();

        // Snoop and core to the same set/way together: snoop lands first.
        rc = mk(3, 1, 'h00055, 1'b1, 3'b100, 0);
        rs = mk(3, 1, 'h40066, 1'b0, 3'b000, 3);
        core_stim.push_back(rc);
        snoop_stim.push_back(rs);
        step();
        step();
        chk("conflict_first_snoop", {write_en, out_rec()}, {1'b1, rs});
        step();
        chk("conflict_then_core", {write_en, out_rec()}, {1'b1, rc});
        step();
        chk("conflict_end", write_en, 1'b0);
        chk("all_drained", pending(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
